// File: rtl/skein_pkg.sv
// Shared types and helpers for the skein512 nonce sweep logic.
package skein_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int LATENCY_DEFAULT = 182;

    // Byte-reverse of a 64-bit word; turns the last hash word into its little-endian value.
    function automatic logic [63:0] le64(input logic [63:0] i_x);
        logic [63:0] r_y;
        for (int i = 0; i < 8; i++) begin
            r_y[8*i +: 8] = i_x[8*(7-i) +: 8];
        end
        return r_y;
    endfunction

endpackage

// File: rtl/skein_nonce_fifo.sv
// Golden-nonce queue: synchronous FIFO, 32-bit entries, push accepted when full if a pop happens in the same cycle.
module skein_nonce_fifo
    import skein_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_push,
    input  logic [31:0] i_data,
    input  logic        i_pop,
    output logic        o_full,
    output logic        o_empty,
    output logic [31:0] o_head
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [31:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic w_do_pop;
    logic w_do_push;

    assign o_full    = (r_count == (AW+1)'(FIFO_DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    // When full, the slot being written is the one being popped this cycle.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/skein_nonce_check.sv
// Nonce sweeper and hash-result checker around the two-phase skein512 pipeline.
module skein_nonce_check
    import skein_pkg::*;
#(
    parameter int LATENCY    = LATENCY_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [31:0]  nonce_first,
    input  logic [31:0]  nonce_last,
    input  logic [63:0]  target,
    output logic [31:0]  nonce,
    input  logic [511:0] hash,
    output logic         busy,
    output logic         done,
    output logic         found_valid,
    output logic [31:0]  found_nonce,
    input  logic         found_ready,
    output logic         overflow,
    output logic [1:0]   dbg_state
);

    state_t              r_state;
    logic                r_phase;
    logic [31:0]         r_nonce;
    logic [31:0]         r_last;
    logic [63:0]         r_target;
    logic [31:0]         r_chk_nonce;
    logic [LATENCY-1:0]  r_tags;
    logic                r_busy;
    logic                r_done;
    logic                r_overflow;

    logic                r_cmp_vld;
    logic [63:0]         r_cmp_val;
    logic [31:0]         r_cmp_nonce;

    logic                w_launch;
    logic [LATENCY-1:0]  w_tags_next;
    logic                w_tag_out;
    logic                w_golden;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic                w_pop;
    logic                w_drop;
    logic                w_unused_hash;

    assign w_launch      = (r_state == ST_RUN) && r_phase;
    assign w_tags_next   = {r_tags[LATENCY-2:0], w_launch};
    assign w_tag_out     = r_tags[LATENCY-1];
    assign w_golden      = r_cmp_vld && (r_cmp_val <= r_target);
    assign w_drop        = w_golden && w_fifo_full && !w_pop;
    assign w_unused_hash = ^hash[511:64];

    // Result port: found_nonce is the queue head while found_valid is high; the head
    // is consumed on any cycle with found_valid && found_ready, and both stay stable until then.
    assign found_valid = !w_fifo_empty;
    assign w_pop       = found_valid && found_ready;

    assign nonce     = r_nonce;
    assign busy      = r_busy;
    assign done      = r_done;
    assign overflow  = r_overflow;
    assign dbg_state = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_phase     <= 1'b0;
            r_nonce     <= '0;
            r_last      <= '0;
            r_target    <= '0;
            r_chk_nonce <= '0;
            r_tags      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_phase <= ~r_phase;
            r_tags  <= w_tags_next;
            r_done  <= 1'b0;
            if (w_tag_out) begin
                r_chk_nonce <= r_chk_nonce + 32'd1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_last      <= nonce_last;
                        r_target    <= target;
                        r_nonce     <= nonce_first;
                        r_chk_nonce <= nonce_first;
                        r_overflow  <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Each nonce is held over a full phase pair, so it steps right after its launch.
                    if (w_launch) begin
                        if (r_nonce == r_last) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_nonce <= r_nonce + 32'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_tags_next == '0) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Hash is registered together with its tag and owning nonce; the compare uses these registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmp_vld   <= 1'b0;
            r_cmp_val   <= '0;
            r_cmp_nonce <= '0;
        end else begin
            r_cmp_vld   <= w_tag_out;
            r_cmp_val   <= le64(hash[63:0]);
            r_cmp_nonce <= r_chk_nonce;
        end
    end

    skein_nonce_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_golden),
        .i_data  (r_cmp_nonce),
        .i_pop   (w_pop),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_head  (found_nonce)
    );

endmodule

// File: doc/skein_nonce_check.md
# skein_nonce_check

Nonce sequencer and result checker wrapped around the `skein512` hashing pipeline. It sweeps a nonce range into the pipeline and tags each launched nonce through a valid shift register matched to the pipeline latency. Each emerging hash is compared against a 64-bit target, and qualifying ("golden") nonces are queued for the host-side reporting logic over a valid/ready port.

## Interface
- `LATENCY`, default 182: cycles from a nonce-launch cycle to the cycle its hash is valid on `hash`.
- `FIFO_DEPTH`, default 4: golden-nonce queue entries; power of two, at least 2.
- `clk` in 1: single clock for all logic.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: one-cycle pulse; begin a sweep. Ignored unless the state is IDLE.
- `nonce_first` in 32: first nonce of the sweep; sampled on `start`.
- `nonce_last` in 32: last nonce, inclusive; sampled on `start`.
- `target` in 64: unsigned threshold; sampled on `start`.
- `nonce` out 32: drives `skein512.nonce`.
- `hash` in 512: driven by `skein512.hash`.
- `busy` out 1: high in RUN or DRAIN.
- `done` out 1: one-cycle pulse when the sweep completes.
- `found_valid` out 1: queue head is valid.
- `found_nonce` out 32: queue head.
- `found_ready` in 1: consumer accepts the head.
- `overflow` out 1: sticky; set when a golden nonce was dropped. Cleared only by `start` or reset.

## Operation
- **Phase.** `phase` toggles every cycle from 0 after reset, in lock-step with the pipeline's two-phase schedule. Cycles with `phase`=1 are launch cycles. Cycles with `phase`=0 carry the second message block.
- **IDLE.**
  - `nonce` holds its last value.
  - On `start`: latch the inputs, load `nonce`=`nonce_first`, clear `overflow`, and enter RUN. Launching begins on the next `phase`=1 cycle.
- **RUN.**
  - Each launch cycle shifts a 1 into the tag shift register (LATENCY bits). Every other cycle shifts a 0.
  - `nonce` advances by 1 on the cycle after each launch, so each value is held across one full phase pair.
  - After the launch of `nonce_last`, `nonce` stops advancing and the state becomes DRAIN.
  - If `nonce_last` < `nonce_first`, the sweep wraps through 0xFFFFFFFF→0. There is no special case.
- **DRAIN.**
  - Zeros are shifted into the tag register.
  - When the register is all zero, pulse `done` and return to IDLE.
- **Check.**
  - The check runs whenever the tag register's output bit is 1, whether in RUN or DRAIN.
  - The check value is `cmp` = byte-reverse of `hash[63:0]`, i.e. the little-endian last word.
  - The nonce is golden if `cmp` <= `target`, as a 64-bit unsigned compare.
  - `chk_nonce` is loaded with `nonce_first` on `start` and increments after every tag-out. It is therefore the nonce belonging to the current hash.
- **Queue.**
  - A golden nonce is pushed if the queue is not full. If it is full, the nonce is dropped and `overflow` is set.
  - Push and pop in the same cycle are allowed when full; the count is unchanged.
  - Pop happens when `found_valid` and `found_ready` are both high.
  - The queue is not flushed by `start`.
- **`start` during RUN or DRAIN** is ignored.
- **Reset mid-sweep.** Reset clears state, tags, queue, `phase` and `overflow` immediately. Results from in-flight hashes are never reported.

## Timing
- **Reset values:**
  - `nonce`=0, `busy`=0, `done`=0.
  - `found_valid`=0, `found_nonce`=0, `overflow`=0.
  - State IDLE, `phase`=0, tags=0.
- `busy` rises the cycle after `start`.
- The first launch is the first `phase`=1 cycle after that.
- For N nonces, the last launch is 2(N−1) cycles after the first.
- `done` fires LATENCY cycles after the last launch, plus one cycle for the compare register. `busy` falls in the same cycle.
- Compare path:
  - `hash` is registered, then compared, then pushed.
  - `found_valid` rises 2 cycles after the hash-valid cycle.
  - `found_valid` and `found_nonce` are registered outputs and stay stable until popped.

## Structure
- Package `skein_pkg` holds:
  - `state_t` (IDLE/RUN/DRAIN).
  - `LATENCY_DEFAULT`.
  - Function `le64()` (byte-reverse of 64 bits), shared with `skein512` output formatting.
- Sub-module `skein_nonce_fifo`: synchronous FIFO, parameter `FIFO_DEPTH`, 32-bit data, with `full`/`empty` flags and the push/pop rules above.
- The tag shift register and compare stay in the top module.

## Test plan
- **Basic sweep.** `nonce_first`=0x100, `nonce_last`=0x103, `target`=all-ones. Expect:
  - found nonces 0x100–0x103 in order;
  - `done` exactly 2·3+LATENCY+1 cycles after the first launch.
- **Target miss.** `target`=0 with a hash model returning `cmp`=1. Expect `found_valid` never asserted and `done` asserted.
- **Selective hit.** A model makes only nonce 0x2A have `cmp`=5, with `target`=5. Expect a single `found_nonce`=0x2A; `cmp`=6 yields nothing.
- **Queue full.** Hold `found_ready`=0 with 6 golden nonces. Expect:
  - `overflow`=1;
  - the queue holds the first 4;
  - draining gives those 4 in order;
  - the next `start` clears `overflow`.
- **Wrap.** `nonce_first`=0xFFFFFFFE, `nonce_last`=0x00000001. Expect nonces FFFFFFFE, FFFFFFFF, 0, 1 to be launched and reported.
- **Reset mid-run.** Deassert `rst_n` during DRAIN. Expect all outputs at their reset values immediately, and no `found_valid` or `done` afterwards.
